// File: rtl/code_compare_engine_if.sv
// rtl/code_compare_engine_if.sv - keypad/lock-controller signal bundle for the code compare engine
interface code_compare_engine_if;
  logic [3:0] digit;
  logic       digit_valid;
  logic       read_input;
  logic [1:0] compareType;
  logic       start;
  logic       store;
  logic       validLength;
  logic       validLengthPC;
  logic       data_ready;
  logic       correct_input;
  logic       busy;
  logic [3:0] entry_count;

  modport master (
    output digit, digit_valid, read_input, compareType, start, store,
    input  validLength, validLengthPC, data_ready, correct_input, busy, entry_count
  );

  modport slave (
    input  digit, digit_valid, read_input, compareType, start, store,
    output validLength, validLengthPC, data_ready, correct_input, busy, entry_count
  );
endinterface

// File: rtl/code_compare_engine.sv
// rtl/code_compare_engine.sv - keypad entry buffer with constant-time serial code compare,
// candidate copy and user-code commit for the digital lock
module code_compare_engine #(
  parameter int                      MAX_DIGITS     = 8,
  parameter int                      MIN_UC         = 4,
  parameter int                      PC_LEN         = 4,
  parameter logic [4*MAX_DIGITS-1:0] PC_VALUE       = 16'h4321,
  parameter logic [4*MAX_DIGITS-1:0] UC_DEFAULT     = 32'h0000_6543,
  parameter int                      UC_DEFAULT_LEN = 4
) (
  input logic                  hwclk,
  input logic                  reset,
  code_compare_engine_if.slave bus
);
  localparam int         IW     = $clog2(MAX_DIGITS);
  localparam logic [3:0] MAX_C  = 4'(MAX_DIGITS);
  localparam logic [3:0] MIN_C  = 4'(MIN_UC);
  localparam logic [3:0] PCL_C  = 4'(PC_LEN);
  localparam logic [3:0] UCL_C  = 4'(UC_DEFAULT_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, CMP, COPY, COMMIT} state_t;

  state_t        state_q, state_d;
  logic [3:0]    entry_q [MAX_DIGITS];
  logic [3:0]    cand_q  [MAX_DIGITS];
  logic [3:0]    uc_q    [MAX_DIGITS];
  logic [3:0]    count_q, cand_len_q, uc_len_q;
  logic          ovf_q;
  logic [IW-1:0] idx_q;
  logic [1:0]    ref_sel_q;
  logic          mismatch_q, vl_start_q;
  logic          data_ready_q, correct_q;
  logic          read_q, store_q;

  logic       read_rise, store_rise, last;
  logic       go_op, done, abort, capture;
  logic [3:0] ref_digit, ref_len;
  logic       slot_mis, cmp_result, valid_len;

  assign read_rise  = bus.read_input & ~read_q;
  assign store_rise = bus.store & ~store_q;
  assign last       = (idx_q == LAST_IDX);
  assign valid_len  = (count_q >= MIN_C) && (count_q <= MAX_C) && !ovf_q;

  always_comb begin
    state_d = state_q;
    go_op   = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: begin
        if (store_rise) begin
          state_d = COMMIT;
        end else if (bus.start && !read_rise) begin
          go_op   = 1'b1;
          state_d = (bus.compareType == 2'b11) ? COPY : CMP;
        end
      end
      CMP, COPY: begin
        if (read_rise) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        if (last) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reference selection follows compareType latched at start: PC, user code, candidate.
  always_comb begin
    ref_digit = cand_q[idx_q];
    ref_len   = cand_len_q;
    case (ref_sel_q)
      2'b00: begin
        ref_digit = PC_VALUE[{idx_q, 2'b00} +: 4];
        ref_len   = PCL_C;
      end
      2'b01: begin
        ref_digit = uc_q[idx_q];
        ref_len   = uc_len_q;
      end
      default: ;
    endcase
  end

  assign slot_mis   = (4'(idx_q) < ref_len) && (entry_q[idx_q] != ref_digit);
  assign cmp_result = (count_q == ref_len) && !ovf_q && !(mismatch_q | slot_mis);
  assign capture    = (state_q == IDLE) && (state_d == IDLE) && bus.read_input &&
                      !read_rise && bus.digit_valid && (bus.digit <= 4'd6);

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      cand_len_q   <= '0;
      uc_len_q     <= UCL_C;
      idx_q        <= '0;
      ref_sel_q    <= '0;
      mismatch_q   <= 1'b0;
      vl_start_q   <= 1'b0;
      data_ready_q <= 1'b0;
      correct_q    <= 1'b0;
      read_q       <= 1'b0;
      store_q      <= 1'b0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
        entry_q[i] <= '0;
        cand_q[i]  <= '0;
        uc_q[i]    <= UC_DEFAULT[4*i +: 4];
      end
    end else begin
      read_q  <= bus.read_input;
      store_q <= bus.store;
      state_q <= state_d;
      idx_q   <= (state_q != IDLE && state_d == state_q) ? idx_q + 1'b1 : '0;

      if (go_op) begin
        ref_sel_q    <= bus.compareType;
        mismatch_q   <= 1'b0;
        vl_start_q   <= valid_len;
        data_ready_q <= 1'b0;
        correct_q    <= 1'b0;
      end

      // The walk never exits early, so a compare always takes MAX_DIGITS cycles.
      if (state_q == CMP && !abort)  mismatch_q    <= mismatch_q | slot_mis;
      if (state_q == COPY && !abort) cand_q[idx_q] <= entry_q[idx_q];
      if (state_q == COMMIT)         uc_q[idx_q]   <= cand_q[idx_q];

      if (done) begin
        if (state_q == COMMIT) begin
          uc_len_q <= cand_len_q;
        end else begin
          if (state_q == COPY) cand_len_q <= count_q;
          data_ready_q <= 1'b1;
          correct_q    <= (state_q == COPY) ? vl_start_q : cmp_result;
          count_q      <= '0;
          ovf_q        <= 1'b0;
        end
      end

      if (read_rise && state_q != COMMIT) begin
        count_q      <= '0;
        ovf_q        <= 1'b0;
        data_ready_q <= 1'b0;
        correct_q    <= 1'b0;
      end

      if (capture) begin
        if (count_q == MAX_C) begin
          ovf_q <= 1'b1;
        end else begin
          entry_q[count_q[IW-1:0]] <= bus.digit;
          count_q                  <= count_q + 4'd1;
        end
      end
    end
  end

  assign bus.validLength   = valid_len;
  assign bus.validLengthPC = (count_q == PCL_C) && !ovf_q;
  assign bus.data_ready    = data_ready_q;
  assign bus.correct_input = correct_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.entry_count   = count_q;
endmodule

// File: doc/code_compare_engine.md
# code_compare_engine

Keypad-code datapath for the digital lock. It captures digit keys into an entry buffer and reports entry-length validity. On command it runs a fixed-latency serial compare of the entry against the factory passcode, the stored user code or the candidate code, copies the entry into the candidate buffer, or commits the candidate as the new user code. It sits between the debounced keypad and the lock controller FSM, which drives `read_input`, `compareType`, `start` and `store`, and consumes `data_ready`, `correct_input` and the valid-length flags.

## Interface
Parameters:
- `MAX_DIGITS`, 8: entry/candidate/user buffer depth in 4-bit digits.
- `MIN_UC`, 4: minimum legal user-code length.
- `PC_LEN`, 4: factory passcode length.
- `PC_VALUE`, 16'h4321: factory passcode; digit i at bits [4i+3:4i], i=0 entered first.
- `UC_DEFAULT`, 32'h0000_6543: user code after reset.
- `UC_DEFAULT_LEN`, 4: user-code length after reset.

Ports:
- `hwclk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `digit` in 4: key code from the keypad.
- `digit_valid` in 1: one-cycle strobe per debounced key press.
- `read_input` in 1: capture enable (level).
- `compareType` in 2: 00 COMPAREPC, 01 COMPAREUC, 10 MATCHUC, 11 STOREUC.
- `start` in 1: one-cycle pulse that launches the `compareType` operation.
- `store` in 1: level; its rising edge commits candidate to user code.
- `validLength` out 1: `MIN_UC` ≤ count ≤ `MAX_DIGITS` and no overflow.
- `validLengthPC` out 1: count == `PC_LEN` and no overflow.
- `data_ready` out 1: result valid, held.
- `correct_input` out 1: compare result, meaningful only while `data_ready`=1.
- `busy` out 1: high in CMP, COPY and COMMIT.
- `entry_count` out 4: digits captured, saturating at `MAX_DIGITS`.

## Operation
- FSM states: IDLE, CMP, COPY, COMMIT.
- Reset: state IDLE. Entry count, overflow, candidate length, `data_ready`, `correct_input` and `busy` are 0. User code = `UC_DEFAULT`/`UC_DEFAULT_LEN`.
- Capture happens only in IDLE with `read_input`=1:
  - a `digit_valid` strobe with `digit` ≤ 6 writes slot[count] and increments count;
  - codes 7–15 (cancel/reprogram/lock keys) are ignored;
  - a digit arriving when count = `MAX_DIGITS` sets overflow and is discarded.
- A rising edge of `read_input` clears the entry count, overflow, `data_ready` and `correct_input`.
- `start` is accepted only in IDLE:
  - compareType 00, 01 or 10 → CMP against the factory passcode, user code or candidate respectively;
  - compareType 11 → COPY.
- CMP:
  - the walk index runs 0..`MAX_DIGITS`-1, one digit per cycle, for all `MAX_DIGITS` cycles regardless of early mismatch (constant time);
  - slots at or beyond the reference length are not compared;
  - result = (lengths equal) AND (no overflow) AND (no slot mismatch);
  - on completion: `data_ready`=1, `correct_input`=result, entry cleared, return to IDLE.
- COPY:
  - `MAX_DIGITS` cycles copy entry to candidate and set candidate length = count;
  - then `data_ready`=1, `correct_input`=`validLength` as sampled at start, entry cleared, return to IDLE.
- COMMIT: on a `store` rising edge in IDLE, `MAX_DIGITS` cycles copy candidate to user code and length, then return to IDLE. `data_ready` and `correct_input` are unchanged.
- Boundary rules:
  - `start` or a `store` edge while busy: ignored; a `store` edge is not queued.
  - `start` and `store` edge in the same IDLE cycle: COMMIT wins, `start` dropped.
  - `digit_valid` in the same cycle as an accepted `start`: digit dropped.
  - Digits are dropped in all non-IDLE states.
  - A `read_input` rising edge during CMP/COPY aborts to IDLE with the entry cleared and no `data_ready`.
  - COMMIT is never aborted.
  - `reset` mid-operation restores the reset values immediately, including the user code.
  - `data_ready` stays high until the next accepted `start` or `read_input` rising edge.

## Timing
- `validLength`, `validLengthPC` and `entry_count` update the cycle after the capturing strobe.
- `start` sampled at edge T → `busy`=1 from T+1 through T+`MAX_DIGITS`. `data_ready`=1 and `busy`=0 at T+`MAX_DIGITS`+1.
- With defaults, CMP/COPY latency = 9 cycles start-to-`data_ready`.
- A `store` edge detected at T → user code updated and `busy`=0 at T+`MAX_DIGITS`+1.
- `correct_input` and `data_ready` change in the same cycle.

## Test plan
- Reset, `read_input`=1, keys 1,2,3,4, `start` with compareType 00 → `validLengthPC`=1, `busy` for 8 cycles, then `data_ready`=1, `correct_input`=1, `entry_count`=0.
- Keys 1,2,3 then compareType 00 start → `validLengthPC`=0, `correct_input`=0 after 9 cycles. Keys 1,2,4,3 → `correct_input`=0.
- Keys 3,4,5,6 with compareType 01 → match against the default user code. Keys 8, 9 and 7 in between are ignored (`entry_count` stays 4).
- Reprogram flow:
  - keys 2,2,2,2,2 with compareType 11 start → `correct_input`=1;
  - re-enter 2,2,2,2,2 with compareType 10 start → `correct_input`=1;
  - `store` rise → `busy` 8 cycles;
  - then 2,2,2,2,2 with compareType 01 → 1, and 3,4,5,6 → 0.
- Nine digits entered → `validLength`=0 and `entry_count`=8; compareType 11 start → `correct_input`=0.
- Start compareType 01, raise `read_input` at cycle 4 → no `data_ready`, `entry_count`=0. Assert `reset` during COMMIT → user code reverts to 3,4,5,6.
